// File: rtl/nn_sequencer_pkg.sv
// Shared definitions for the nn datapath sequencer and its bus-register wrapper.
package nn_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      FEED  = 2'd2,
      DRAIN = 2'd3
   } seq_state_t;

   localparam int unsigned NN_BITS  = 24;
   localparam int unsigned NN_WIDTH = 784;
   localparam int unsigned IDX_W    = 10;
   localparam int unsigned CNT_W    = 16;

endpackage

// File: rtl/nn_sequencer_cnt.sv
// Loadable down-counter with zero flag, used to time the CLEAR and DRAIN phases.
module nn_seq_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/nn_sequencer.sv
// Feeds one image of pixels into the nn datapath: clear, stream pixels, wait, capture prediction.
module nn_sequencer
   import nn_sequencer_pkg::*;
#(
   parameter int unsigned BITS       = NN_BITS,
   parameter int unsigned WIDTH      = NN_WIDTH,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned RESULT_LAT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   input  logic             pix_valid,
   input  logic [BITS-1:0]  pix_data,
   output logic             pix_ready,
   output logic             nn_reset,
   output logic [IDX_W-1:0] nn_pixel_counter,
   output logic [BITS-1:0]  nn_input_pixel,
   input  logic [BITS-1:0]  nn_predict_num,
   output logic [BITS-1:0]  result,
   output logic             result_valid
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRN_LOAD = CNT_W'(RESULT_LAT - 1);

   seq_state_t       state;
   logic [IDX_W-1:0] idx;
   logic             hs;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_val;

   assign hs = pix_valid & pix_ready;

   // Abort suppresses every counter action so a cancelled image leaves no pending phase.
   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;
      if (!abort) begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt_load = 1'b1;
                  cnt_val  = CLR_LOAD;
               end
            end
            FEED: begin
               if (hs && (idx == LAST_IDX)) begin
                  cnt_load = 1'b1;
                  cnt_val  = DRN_LOAD;
               end
            end
            CLEAR, DRAIN: cnt_dec = ~cnt_zero;
            default: ;
         endcase
      end
   end

   nn_seq_cnt #(
      .W (CNT_W)
   ) u_phase_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         idx              <= '0;
         busy             <= 1'b0;
         pix_ready        <= 1'b0;
         nn_reset         <= 1'b0;
         nn_pixel_counter <= '0;
         nn_input_pixel   <= '0;
         result           <= '0;
         result_valid     <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (abort && (state != IDLE)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_ready <= 1'b0;
            nn_reset  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state    <= CLEAR;
                     idx      <= '0;
                     busy     <= 1'b1;
                     nn_reset <= 1'b1;
                  end
               end
               CLEAR: begin
                  if (cnt_zero) begin
                     state     <= FEED;
                     nn_reset  <= 1'b0;
                     pix_ready <= 1'b1;
                  end
               end
               FEED: begin
                  if (hs) begin
                     nn_input_pixel   <= pix_data;
                     nn_pixel_counter <= idx;
                     if (idx == LAST_IDX) begin
                        state     <= DRAIN;
                        pix_ready <= 1'b0;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  if (cnt_zero) begin
                     state        <= IDLE;
                     busy         <= 1'b0;
                     result       <= nn_predict_num;
                     result_valid <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 24, giving the pixel and result width.
REQ-002 SHALL have parameter WIDTH, default 784, giving the number of pixels per image.
REQ-003 SHALL have parameter RST_CYCLES, default 2, giving the number of cycles nn_reset is held high before feeding.
REQ-004 SHALL have parameter RESULT_LAT, default 4, giving the cycles waited after the last pixel before capturing nn_predict_num.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begin an image (single-cycle request).
REQ-008 SHALL have port abort, input, 1 bit: cancel the image in progress.
REQ-009 SHALL have port busy, output, 1 bit: high in CLEAR, FEED and DRAIN.
REQ-010 SHALL have port pix_valid, input, 1 bit: pixel offered.
REQ-011 SHALL have port pix_data, input, BITS bits: pixel value.
REQ-012 SHALL have port pix_ready, output, 1 bit: pixel accepted when high together with pix_valid.
REQ-013 SHALL have port nn_reset, output, 1 bit: datapath clear, active-high.
REQ-014 SHALL have port nn_pixel_counter, output, 10 bits: pixel index to the datapath.
REQ-015 SHALL have port nn_input_pixel, output, BITS bits: pixel value to the datapath.
REQ-016 SHALL have port nn_predict_num, input, BITS bits: datapath result.
REQ-017 SHALL have port result, output, BITS bits: captured prediction.
REQ-018 SHALL have port result_valid, output, 1 bit: one-cycle pulse when result updates.

Function
REQ-019 SHALL implement the states IDLE, CLEAR, FEED and DRAIN.
REQ-020 In IDLE, start=1 SHALL move to CLEAR on the next edge, load the phase counter with RST_CYCLES-1 and clear the pixel index idx to 0.
REQ-021 In any non-IDLE state, start SHALL be ignored.
REQ-022 CLEAR SHALL drive nn_reset=1 for exactly RST_CYCLES cycles and then enter FEED.
REQ-023 nn_reset SHALL be 0 in every state other than CLEAR.
REQ-024 FEED SHALL drive pix_ready=1.
REQ-025 pix_ready SHALL be 0 in every state other than FEED.
REQ-026 On each FEED handshake, nn_input_pixel<=pix_data and nn_pixel_counter<=idx SHALL be registered, giving one cycle of latency from handshake to the datapath, and idx SHALL increment.
REQ-027 FEED SHALL tolerate pix_valid gaps of any length: idx and the nn_* outputs SHALL hold their values while no handshake occurs.
REQ-028 The handshake at idx==WIDTH-1 SHALL move to DRAIN, load the phase counter with RESULT_LAT-1, and SHALL NOT wrap idx beyond WIDTH-1.
REQ-029 DRAIN SHALL wait RESULT_LAT cycles, then register result<=nn_predict_num, pulse result_valid for exactly one cycle and return to IDLE.
REQ-030 result SHALL hold its value until the next capture.
REQ-031 busy SHALL be 1 exactly while the state is CLEAR, FEED or DRAIN.
REQ-032 abort=1 in CLEAR, FEED or DRAIN SHALL enter IDLE on the next edge with no result_valid pulse and with result unchanged.
REQ-033 abort=1 in IDLE SHALL have no effect.
REQ-034 When start and abort are both 1 in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-035 When abort and the final DRAIN cycle coincide, abort SHALL win and no capture SHALL occur.
REQ-036 Index arithmetic SHALL be unsigned on 10 bits, and WIDTH SHALL be at most 1024.
REQ-037 RST_CYCLES and RESULT_LAT SHALL each be at least 1.

Reset
REQ-038 While reset is high (asynchronous): state=IDLE, idx=0, phase counter=0.
REQ-039 While reset is high: busy=0, pix_ready=0, nn_reset=0, result_valid=0.
REQ-040 While reset is high: nn_pixel_counter=0, nn_input_pixel=0, result=0.
REQ-041 Deassertion of reset SHALL take effect on the next clk edge, and assertion mid-image SHALL discard the image.

Structure
REQ-042 A shared package SHALL hold the state encoding (2 bits: IDLE=0, CLEAR=1, FEED=2, DRAIN=3) and the default values of BITS and WIDTH, for reuse by the bus-register wrapper.
REQ-043 The block SHALL contain one sub-module, nn_seq_cnt: a loadable down-counter with a zero flag, instantiated for the CLEAR and DRAIN phase timing.
REQ-044 The block SHALL be a direct driver for the nn datapath ports: reset, pixel_counter, input_pixel and predict_num.

Verification
REQ-045 Reset, then start with pix_valid held 1 and pixel i = i -> nn_reset high for 2 cycles; nn_pixel_counter steps 0..783 one cycle after each handshake; result_valid pulses 4 cycles after the idx 783 handshake with result = the nn_predict_num stub value 24'h000007.
REQ-046 pix_valid toggled 1-0-1 every cycle through FEED -> exactly 784 handshakes, no index skipped or repeated, image completes in 2+1568+4 cycles ±1.
REQ-047 abort asserted at idx=400 -> IDLE next cycle, busy=0, no result_valid, result keeps its previous value; a following start completes normally.
REQ-048 start pulsed again during FEED, and start+abort together in IDLE -> both ignored, state trace unchanged.
REQ-049 Asynchronous reset mid-DRAIN, between clk edges -> outputs zero immediately; no result_valid after release.
REQ-050 Parameters WIDTH=4, RESULT_LAT=1 -> nn_pixel_counter sequence 0,1,2,3; result_valid exactly 1 cycle after the last handshake.
